// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner
//  Brief    : 4x4 matrix keypad scanner with press/release debounce and
//             one-hot key code output. Optional KEY_STROBE_EN adds key_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] onehot,
    output logic        key_down
`ifdef KEY_STROBE_EN
    ,
    output logic        key_valid
`endif
);

    localparam int c_SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_col, w_col_nxt;
    logic [1:0]          r_row, w_row_nxt;
    logic [3:0]          r_pat, w_pat_nxt;
    logic [c_SLOT_W-1:0] r_slot, w_slot_nxt;
    logic [c_DEB_W-1:0]  r_deb, w_deb_nxt;
    logic [15:0]         r_onehot, w_onehot_nxt;
    logic                r_key_down, w_key_down_nxt;
    logic [3:0]          r_sync1, r_rs;

    logic                w_one_low;
    logic [1:0]          w_low_row;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_sync1 <= 4'hF;
            r_rs    <= 4'hF;
        end else begin
            r_sync1 <= row_in;
            r_rs    <= r_sync1;
        end
    end

    // A press is only considered when exactly one row reads low.
    always_comb begin
        w_one_low = 1'b1;
        w_low_row = 2'd0;
        case (r_rs)
            4'b1110: w_low_row = 2'd0;
            4'b1101: w_low_row = 2'd1;
            4'b1011: w_low_row = 2'd2;
            4'b0111: w_low_row = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_SCAN;
            r_col      <= 2'd0;
            r_row      <= 2'd0;
            r_pat      <= 4'hF;
            r_slot     <= '0;
            r_deb      <= '0;
            r_onehot   <= 16'h0000;
            r_key_down <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_pat      <= w_pat_nxt;
            r_slot     <= w_slot_nxt;
            r_deb      <= w_deb_nxt;
            r_onehot   <= w_onehot_nxt;
            r_key_down <= w_key_down_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_pat_nxt      = r_pat;
        w_slot_nxt     = r_slot;
        w_deb_nxt      = r_deb;
        w_onehot_nxt   = r_onehot;
        w_key_down_nxt = r_key_down;
        unique case (r_state)
            ST_SCAN: begin
                if (r_slot == c_SLOT_LAST) begin
                    w_slot_nxt = '0;
                    if (w_one_low) begin
                        w_state_nxt = ST_CONFIRM;
                        w_row_nxt   = w_low_row;
                        w_pat_nxt   = r_rs;
                        w_deb_nxt   = '0;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_slot_nxt = r_slot + c_SLOT_W'(1);
                end
            end
            ST_CONFIRM: begin
                if (r_rs != r_pat) begin
                    w_state_nxt = ST_SCAN;
                    w_col_nxt   = r_col + 2'd1;
                    w_slot_nxt  = '0;
                    w_deb_nxt   = '0;
                end else if (r_deb == c_DEB_LAST) begin
                    w_state_nxt    = ST_HOLD;
                    w_deb_nxt      = '0;
                    w_onehot_nxt   = 16'h0001 << {r_row, r_col};
                    w_key_down_nxt = 1'b1;
                end else begin
                    w_deb_nxt = r_deb + c_DEB_W'(1);
                end
            end
            ST_HOLD: begin
                // Only the latched row matters; other rows are ignored.
                if (r_rs[r_row]) begin
                    if (r_deb == c_DEB_LAST) begin
                        w_state_nxt    = ST_SCAN;
                        w_col_nxt      = r_col + 2'd1;
                        w_slot_nxt     = '0;
                        w_deb_nxt      = '0;
                        w_onehot_nxt   = 16'h0000;
                        w_key_down_nxt = 1'b0;
                    end else begin
                        w_deb_nxt = r_deb + c_DEB_W'(1);
                    end
                end else begin
                    w_deb_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
                w_slot_nxt  = '0;
                w_deb_nxt   = '0;
            end
        endcase
    end

`ifdef KEY_STROBE_EN
    logic r_key_valid;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= (r_state == ST_CONFIRM) && (w_state_nxt == ST_HOLD);
        end
    end

    assign key_valid = r_key_valid;
`endif

    assign col_out  = ~(4'b0001 << r_col);
    assign onehot   = r_onehot;
    assign key_down = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_matrix_scanner
//  Brief    : Self-checking bench for keypad_matrix_scanner (SCAN_DIV=4,
//             DEBOUNCE_CNT=8) with a physical keypad model driving row_in.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

    localparam int c_S         = 4;
    localparam int c_D         = 8;
    localparam int c_PRESS_MAX = 2 + 4 * c_S + c_D + 1;
    localparam int c_RELEASE   = 2 + c_D;

    logic        clk = 1'b0;
    logic        RSTn;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] onehot;
    logic        key_down;
`ifdef KEY_STROBE_EN
    logic        key_valid;
`endif

    logic [15:0] keys = 16'h0000;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .SCAN_DIV     (c_S),
        .DEBOUNCE_CNT (c_D)
    ) dut (
        .clk      (clk),
        .RSTn     (RSTn),
        .row_in   (row_in),
        .col_out  (col_out),
        .onehot   (onehot),
        .key_down (key_down)
`ifdef KEY_STROBE_EN
        ,
        .key_valid(key_valid)
`endif
    );

    // Physical keypad: a held key shorts its row to its column when driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    typedef struct {
        int          row;
        int          col;
        logic [15:0] code;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] key_code(input int row, input int col);
        logic [15:0] one;
        one = 16'h0001;
        return one << (row * 4 + col);
    endfunction

    function automatic logic [3:0] col_drive(input int col);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (col % 4));
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_code(input logic [15:0] exp, input string name);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < c_PRESS_MAX) begin
            k++;
            tick(1);
            seen = (onehot != 16'h0);
        end
        check({name, "_latency"}, {31'd0, seen}, 32'd1);
        check({name, "_code"}, onehot, exp);
    endtask

    task automatic press(input int row, input int col, input string name);
        keys[row*4+col] = 1'b1;
        wait_code(key_code(row, col), name);
        check({name, "_key_down"}, key_down, 1);
        check({name, "_col_frozen"}, col_out, col_drive(col));
    endtask

    // Releases every key and checks clear lands exactly 2+DEBOUNCE_CNT cycles later.
    task automatic release_all(input logic [15:0] code, input int col, input string name);
        keys = 16'h0000;
        tick(c_RELEASE - 1);
        check({name, "_still_held"}, onehot, code);
        tick(1);
        check({name, "_cleared"}, onehot, 0);
        check({name, "_key_up"}, key_down, 0);
        check({name, "_resume_col"}, col_out, col_drive(col + 1));
    endtask

    logic [15:0] prev_oh  = 16'h0000;
    int          zero_run = 1000;

    always @(negedge clk) begin
        check("onehot_bits", {31'd0, ($countones(onehot) <= 1)}, 32'd1);
        check("key_down_rule", key_down, {31'd0, (onehot != 16'h0)});
        check("col_onecold", $countones(col_out), 3);
        if (prev_oh != 16'h0 && onehot != 16'h0) check("no_code_swap", onehot, prev_oh);
        if (prev_oh == 16'h0 && onehot != 16'h0)
            check("zero_gap", {31'd0, (zero_run >= c_S)}, 32'd1);
`ifdef KEY_STROBE_EN
        check("key_valid", key_valid, {31'd0, (prev_oh == 16'h0 && onehot != 16'h0)});
`endif
        zero_run = (onehot == 16'h0) ? zero_run + 1 : 0;
        prev_oh  = onehot;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[6];
        logic [3:0]  seen_cols;
        int          r, c, dur;

        vecs[0] = '{2, 1, 16'h0200};
        vecs[1] = '{0, 0, 16'h0001};
        vecs[2] = '{3, 3, 16'h8000};
        vecs[3] = '{1, 2, 16'h0040};
        vecs[4] = '{3, 2, 16'h4000};
        vecs[5] = '{0, 3, 16'h0008};

        // Reset state and idle column rotation
        RSTn = 1'b0;
        tick(3);
        check("rst_col", col_out, 4'b1110);
        check("rst_onehot", onehot, 0);
        check("rst_key_down", key_down, 0);
        @(negedge clk);
        RSTn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            check("idle_scan_col", col_out, col_drive(k / 4));
            check("idle_onehot", onehot, 0);
        end

        // Table-driven single presses
        for (int i = 0; i < 6; i++) begin
            press(vecs[i].row, vecs[i].col, "table_press");
            check("table_expected", onehot, vecs[i].code);
            for (int h = 0; h < 5; h++) begin
                tick(1);
                check("table_hold", onehot, vecs[i].code);
            end
            release_all(vecs[i].code, vecs[i].col, "table_release");
            tick(5);
        end

        // Bouncing contact on row 2 / col 1
        for (int i = 0; i < 10; i++) begin
            keys[9] = (i % 2 == 0);
            for (int t = 0; t < 3; t++) begin
                tick(1);
                check("bounce_quiet", onehot, 0);
            end
        end
        keys[9] = 1'b1;
        wait_code(16'h0200, "bounce_settle");
        release_all(16'h0200, 1, "bounce_release");
        tick(4);

        // Two rows low in one column: never accepted, scanning continues
        keys = 16'h1001;
        seen_cols = 4'h0;
        for (int t = 0; t < 40; t++) begin
            tick(1);
            check("dual_row_quiet", onehot, 0);
            seen_cols = seen_cols | ~col_out;
        end
        check("dual_row_scanning", seen_cols, 4'hF);
        keys = 16'h0000;
        tick(5);

        // Second key in another row while holding row 3 / col 2
        press(3, 2, "hold_first");
        keys[2] = 1'b1;
        for (int t = 0; t < 30; t++) begin
            tick(1);
            check("second_key_ignored", onehot, 16'h4000);
        end
        release_all(16'h4000, 2, "second_release");
        tick(4);

        // Reset asserted mid-HOLD with key still held
        press(3, 3, "pre_reset");
        #3;
        RSTn = 1'b0;
        #1;
        check("midrst_onehot", onehot, 0);
        check("midrst_col", col_out, 4'b1110);
        check("midrst_key_down", key_down, 0);
        tick(2);
        @(negedge clk);
        RSTn = 1'b1;
        wait_code(16'h8000, "post_reset");
        release_all(16'h8000, 3, "post_reset_release");
        tick(3);

        // Randomized taps and holds against the keypad model
        for (int it = 0; it < 24; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                keys[r*4+c] = 1'b1;
                dur = $urandom_range(1, c_D);
                for (int t = 0; t < dur; t++) begin
                    tick(1);
                    check("rand_tap_quiet", onehot, 0);
                end
                keys = 16'h0000;
                for (int t = 0; t < 4; t++) begin
                    tick(1);
                    check("rand_tap_after", onehot, 0);
                end
            end else begin
                press(r, c, "rand_press");
                dur = $urandom_range(0, 15);
                for (int t = 0; t < dur; t++) begin
                    tick(1);
                    check("rand_hold", onehot, key_code(r, c));
                end
                release_all(key_code(r, c), c, "rand_release");
            end
            tick($urandom_range(0, 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
